// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe
//   Pipelined IEEE-754-style floating-point adder/subtractor with
//   round-to-nearest-even, NaN/Inf handling and exception flags.
//   The exponent and fraction widths are parameters, so fp16, bf16 and fp32
//   are all built from this one source.
//
//   Operands are registered on acceptance. Three stages then follow:
//     S1 align  : swap by magnitude, decode specials, right-shift smaller
//     S2 add    : add/subtract aligned significands
//     S3 round  : normalise, round to nearest even, pack into x/flags
//   Results appear 3 cycles after acceptance.
//
//   Optional feature macro: FPADD_SUBNORMAL_EN
//     defined   : gradual underflow (subnormal inputs and results)
//     undefined : flush mode (subnormal inputs read as signed zero, tiny
//                 results flushed to signed zero with underflow|inexact)
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   operand pair present         in_ready  pipeline accepts
//   a, b       operands {sign, exp, frac}   sub       1: a-b, 0: a+b
//   out_valid  result present               out_ready consumer accepts
//   x          result                       flags     {invalid, overflow,
//                                                      underflow, inexact}
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. in_ready = !out_valid | out_ready; when it is low every stage holds,
// when it is high every stage advances (bubbles included), so x/flags stay
// stable while out_valid=1 and out_ready=0.
module fp_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] x,
  output logic [3:0]   flags
);
  // Significand: {hidden, frac, guard, round, sticky}
  localparam int SW = MAN_W + 4;
  localparam logic [EXP_W-1:0] EMAX   = '1;
  localparam logic [W-1:0]     QNAN   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W:0]   SH_LIM = (EXP_W+1)'(MAN_W + 3);

  // ---------------- operand register ----------------
  logic         v0_q, sub_q;
  logic [W-1:0] opa_q, opb_q;

  // ---------------- S1 align ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb, exa, exb, big_e, sml_e, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [SW-1:0]    siga, sigb, big_sig, sml_sig, sml_al, lost;
  logic             a_nan, b_nan, a_inf, b_inf, a_big;
  logic             spc1_d;
  logic [W-1:0]     spx1_d;
  logic [3:0]       spf1_d;

  assign sa = opa_q[W-1];
  assign sb = opb_q[W-1] ^ sub_q;   // effective sign of b
  assign ea = opa_q[MAN_W +: EXP_W];
  assign eb = opb_q[MAN_W +: EXP_W];
  assign fa = opa_q[MAN_W-1:0];
  assign fb = opb_q[MAN_W-1:0];

  always_comb begin
    a_nan = (ea == EMAX) && (fa != '0);
    b_nan = (eb == EMAX) && (fb != '0);
    a_inf = (ea == EMAX) && (fa == '0);
    b_inf = (eb == EMAX) && (fb == '0);
`ifdef FPADD_SUBNORMAL_EN
    siga = {(ea != '0), fa, 3'b000};
    sigb = {(eb != '0), fb, 3'b000};
`else
    siga = (ea == '0) ? '0 : {1'b1, fa, 3'b000};
    sigb = (eb == '0) ? '0 : {1'b1, fb, 3'b000};
`endif
    // zeros and subnormals sit at effective exponent 1
    exa = (ea == '0) ? EXP_W'(1) : ea;
    exb = (eb == '0) ? EXP_W'(1) : eb;
    a_big   = ({exa, siga} >= {exb, sigb});
    big_sig = a_big ? siga : sigb;
    sml_sig = a_big ? sigb : siga;
    big_e   = a_big ? exa : exb;
    sml_e   = a_big ? exb : exa;
    diff    = big_e - sml_e;
    sml_al  = sml_sig >> diff;
    lost    = sml_sig & ~({SW{1'b1}} << diff);
    if ({1'b0, diff} >= SH_LIM) sml_al = {{(SW-1){1'b0}}, |sml_sig};
    else                        sml_al[0] = sml_al[0] | (|lost);

    spc1_d = 1'b0;
    spx1_d = '0;
    spf1_d = 4'b0000;
    if (a_nan || b_nan) begin
      spc1_d = 1'b1; spx1_d = QNAN;
    end else if (a_inf && b_inf && (sa != sb)) begin
      spc1_d = 1'b1; spx1_d = QNAN; spf1_d = 4'b1000;
    end else if (a_inf) begin
      spc1_d = 1'b1; spx1_d = {sa, EMAX, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      spc1_d = 1'b1; spx1_d = {sb, EMAX, {MAN_W{1'b0}}};
    end
  end

  logic             v1_q, sgn1_q, esub1_q, spc1_q;
  logic [SW-1:0]    big1_q, sml1_q;
  logic [EXP_W-1:0] exp1_q;
  logic [W-1:0]     spx1_q;
  logic [3:0]       spf1_q;

  // ---------------- S2 add ----------------
  // Never negative: the larger magnitude is always the minuend.
  logic [SW:0] sum2_d;
  assign sum2_d = esub1_q ? ({1'b0, big1_q} - {1'b0, sml1_q})
                          : ({1'b0, big1_q} + {1'b0, sml1_q});

  logic             v2_q, sgn2_q, esub2_q, spc2_q;
  logic [SW:0]      sum2_q;
  logic [EXP_W-1:0] exp2_q;
  logic [W-1:0]     spx2_q;
  logic [3:0]       spf2_q;

  // ---------------- S3 normalise / round / pack ----------------
  logic [SW-1:0]    m;
  logic [EXP_W:0]   e;
  logic [MAN_W+1:0] mant;
  logic             g, r, st, inc, inexact, tiny, zero, ovf;
  int               lz, room, sh;
  logic [W-1:0]     x_d;
  logic [3:0]       flags_d;

  always_comb begin
    m    = sum2_q[SW-1:0];
    e    = {1'b0, exp2_q};
    lz   = SW;
    room = 0;
    sh   = 0;
    if (sum2_q[SW]) begin
      // carry out: shift right, dropped bit folds into sticky
      m = sum2_q[SW:1] | {{(SW-1){1'b0}}, sum2_q[0]};
      e = {1'b0, exp2_q} + (EXP_W+1)'(1);
    end else begin
      for (int i = 0; i < SW; i++) if (sum2_q[i]) lz = SW - 1 - i;
      // left shift stops at exponent 1; anything still unnormalised is tiny
      room = int'(exp2_q) - 1;
      sh   = (lz < room) ? lz : room;
      m    = sum2_q[SW-1:0] << sh;
      e    = {1'b0, exp2_q} - (EXP_W+1)'(sh);
    end
    zero    = (sum2_q == '0);
    tiny    = ~m[SW-1];
    g       = m[2];
    r       = m[1];
    st      = m[0];
    inexact = g | r | st;
    inc     = g & (r | st | m[3]);
    mant    = {1'b0, m[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    if (mant[MAN_W+1]) begin
      mant = mant >> 1;
      e    = e + (EXP_W+1)'(1);
    end
    ovf = (e >= {1'b0, EMAX});

    x_d     = '0;
    flags_d = 4'b0000;
    if (spc2_q) begin
      x_d = spx2_q; flags_d = spf2_q;
    end else if (zero) begin
      // exact cancellation of opposite signs gives +0
      x_d = {(esub2_q ? 1'b0 : sgn2_q), {(W-1){1'b0}}};
`ifndef FPADD_SUBNORMAL_EN
    end else if (tiny) begin
      x_d = {sgn2_q, {(W-1){1'b0}}}; flags_d = 4'b0011;
`endif
    end else if (ovf) begin
      x_d = {sgn2_q, EMAX, {MAN_W{1'b0}}}; flags_d = 4'b0101;
    end else begin
      // a subnormal that rounds up into the hidden bit becomes exponent 1
      x_d = {sgn2_q, (mant[MAN_W] ? e[EXP_W-1:0] : {EXP_W{1'b0}}), mant[MAN_W-1:0]};
`ifdef FPADD_SUBNORMAL_EN
      flags_d = {2'b00, tiny & inexact, inexact};
`else
      flags_d = {3'b000, inexact};
`endif
    end
  end

  logic         out_valid_q;
  logic [W-1:0] x_q;
  logic [3:0]   flags_q;

  assign in_ready  = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
  assign x         = x_q;
  assign flags     = flags_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0_q <= 1'b0; sub_q <= 1'b0; opa_q <= '0; opb_q <= '0;
      v1_q <= 1'b0; sgn1_q <= 1'b0; esub1_q <= 1'b0; spc1_q <= 1'b0;
      big1_q <= '0; sml1_q <= '0; exp1_q <= '0; spx1_q <= '0; spf1_q <= '0;
      v2_q <= 1'b0; sgn2_q <= 1'b0; esub2_q <= 1'b0; spc2_q <= 1'b0;
      sum2_q <= '0; exp2_q <= '0; spx2_q <= '0; spf2_q <= '0;
      out_valid_q <= 1'b0; x_q <= '0; flags_q <= '0;
    end else if (in_ready) begin
      v0_q    <= in_valid;
      sub_q   <= sub;
      opa_q   <= a;
      opb_q   <= b;
      v1_q    <= v0_q;
      sgn1_q  <= a_big ? sa : sb;
      esub1_q <= sa ^ sb;
      spc1_q  <= spc1_d;
      big1_q  <= big_sig;
      sml1_q  <= sml_al;
      exp1_q  <= big_e;
      spx1_q  <= spx1_d;
      spf1_q  <= spf1_d;
      v2_q    <= v1_q;
      sgn2_q  <= sgn1_q;
      esub2_q <= esub1_q;
      spc2_q  <= spc1_q;
      sum2_q  <= sum2_d;
      exp2_q  <= exp1_q;
      spx2_q  <= spx1_q;
      spf2_q  <= spf1_q;
      out_valid_q <= v2_q;
      x_q     <= x_d;
      flags_q <= flags_d;
    end
  end
endmodule
